// File: rtl/nervous_pulse_transmitter_if.sv
// Frame request and serial output bundle for nervous_pulse_transmitter.
//   start      : frame request, sampled every clock edge
//   mode       : 00 pattern, 01 alternating, 10 burst of ones, 11 reserved
//   pattern    : frame word for mode 00, sent MSB first
//   length     : repetition / pair / ones count, valid range 1..15
//   outputdata : serial bit stream, idle level 0
//   busy       : frame (including tail bit) on outputdata
//   done       : one-cycle completion pulse
//   error      : one-cycle pulse on a rejected start
interface nervous_pulse_transmitter_if;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned PAT_W  = 8;
    localparam int unsigned LEN_W  = 4;

    logic              start;
    logic [MODE_W-1:0] mode;
    logic [PAT_W-1:0]  pattern;
    logic [LEN_W-1:0]  length;
    logic              outputdata;
    logic              busy;
    logic              done;
    logic              error;

    // Requester side
    modport master (
        output start, mode, pattern, length,
        input  outputdata, busy, done, error
    );

    // Transmitter side
    modport slave (
        input  start, mode, pattern, length,
        output outputdata, busy, done, error
    );
endinterface

// File: rtl/nervous_pulse_transmitter.sv
// Serial pulse-frame generator: on an accepted start it streams a pattern,
// alternating or burst frame one bit per clock, then a single 0 tail bit,
// then a one-cycle done pulse.
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : request inputs and registered serial/status outputs
module nervous_pulse_transmitter (
    input  logic                        clock,
    input  logic                        resetn,
    nervous_pulse_transmitter_if.slave  bus
);
    localparam int unsigned CNT_W = 7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] MODE_PAT   = 2'b00;
    localparam logic [1:0] MODE_ALT   = 2'b01;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       mode_q,    mode_d;
    logic [7:0]       pat_q,     pat_d;
    logic             out_q,     out_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    // Total frame bits minus one; this is the counter load value.
    function automatic logic [CNT_W-1:0] last_index(input logic [1:0] m,
                                                    input logic [3:0] l);
        case (m)
            MODE_PAT: last_index = 7'({l, 3'b000}) - 7'd1;
            MODE_ALT: last_index = 7'({l, 1'b0}) - 7'd1;
            default:  last_index = 7'(l) - 7'd1;
        endcase
    endfunction

    // Bit sent while the down-counter holds c. Pattern frames are multiples
    // of 8 bits, so c[2:0] directly selects the pattern bit MSB-first; the
    // alternating frame has odd c on its 0 bits.
    function automatic logic frame_bit(input logic [1:0]       m,
                                       input logic [7:0]       p,
                                       input logic [CNT_W-1:0] c);
        case (m)
            MODE_PAT: frame_bit = p[c[2:0]];
            MODE_ALT: frame_bit = ~c[0];
            default:  frame_bit = 1'b1;
        endcase
    endfunction

    // State and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            pat_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_RSVD || bus.length == 4'd0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        mode_d  = bus.mode;
                        pat_d   = bus.pattern;
                        cnt_d   = last_index(bus.mode, bus.length);
                        out_d   = frame_bit(bus.mode, bus.pattern,
                                            last_index(bus.mode, bus.length));
                        busy_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = TAIL;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                    out_d = frame_bit(mode_q, pat_q, cnt_q - 7'd1);
                end
            end
            TAIL: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.outputdata = out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;
endmodule

// File: tb/tb_nervous_pulse_transmitter.sv
// Directed bench for nervous_pulse_transmitter: a frame-level model predicts
// every output each cycle, and literal expectations pin the main scenarios.
module tb_nervous_pulse_transmitter;
    logic clock;
    logic resetn;

    nervous_pulse_transmitter_if bus ();

    nervous_pulse_transmitter dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending per-edge expectations {out, busy, done, error}
    logic [3:0] exp_q[$];
    logic       bits_q[$];
    logic       e_out, e_busy, e_done, e_err;
    logic       model_valid = 1'b0;

    always @(posedge clock) begin
        e_out = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (!resetn) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            {e_out, e_busy, e_done, e_err} = exp_q.pop_front();
        end else if (bus.start) begin
            if (bus.mode == 2'b11 || bus.length == 4'd0) begin
                e_err = 1'b1;
            end else begin
                bits_q.delete();
                for (int r = 0; r < int'(bus.length); r++) begin
                    if (bus.mode == 2'b00) begin
                        for (int i = 7; i >= 0; i--) bits_q.push_back(bus.pattern[i]);
                    end else if (bus.mode == 2'b01) begin
                        bits_q.push_back(1'b0);
                        bits_q.push_back(1'b1);
                    end else begin
                        bits_q.push_back(1'b1);
                    end
                end
                e_out  = bits_q[0];
                e_busy = 1'b1;
                for (int i = 1; i < bits_q.size(); i++)
                    exp_q.push_back({bits_q[i], 1'b1, 1'b0, 1'b0});
                exp_q.push_back(4'b0100);   // tail
                exp_q.push_back(4'b0010);   // done
                exp_q.push_back(4'b0000);   // back to idle, start ignored
            end
        end
        model_valid = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (model_valid) begin
            chk("cyc_outputdata", int'(bus.outputdata), int'(e_out));
            chk("cyc_busy",       int'(bus.busy),       int'(e_busy));
            chk("cyc_done",       int'(bus.done),       int'(e_done));
            chk("cyc_error",      int'(bus.error),      int'(e_err));
            chk("cyc_done_and_error", int'(bus.done & bus.error), 0);
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    // Request a frame and record n cycles of outputs (first bit in stream MSB side)
    task automatic run_frame(input logic [1:0] m, input logic [7:0] p,
                             input logic [3:0] l, input int n, input bit hold,
                             output logic [31:0] stream, output int busy_cnt,
                             output int done_at, output int done_cnt,
                             output int err_cnt);
        bus.mode = m; bus.pattern = p; bus.length = l; bus.start = 1'b1;
        stream = '0; busy_cnt = 0; done_at = 0; done_cnt = 0; err_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            stream   = {stream[30:0], bus.outputdata};
            busy_cnt += int'(bus.busy);
            err_cnt  += int'(bus.error);
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (hold) begin
                bus.pattern = ~bus.pattern;
            end else begin
                // Scramble inputs after acceptance; frame in flight must not change
                bus.start   = 1'b0;
                bus.mode    = ~m;
                bus.pattern = ~p;
                bus.length  = l + 4'd3;
            end
        end
        bus.start = 1'b0;
    endtask

    logic [31:0] s;
    int bc, da, dc, ec;

    initial begin
        resetn = 1'b0;
        bus.start = 1'b0; bus.mode = 2'b00; bus.pattern = 8'h00; bus.length = 4'd0;
        idle(3);
        chk("reset_outputdata", int'(bus.outputdata), 0);
        chk("reset_busy",       int'(bus.busy), 0);
        resetn = 1'b1;
        idle(2);

        // Pattern B2, one repetition
        run_frame(2'b00, 8'hB2, 4'd1, 11, 1'b0, s, bc, da, dc, ec);
        chk("b2_stream", int'(s[10:0]), int'(11'b10110010000));
        chk("b2_busy",   bc, 9);
        chk("b2_done_at", da, 10);
        chk("b2_done_cnt", dc, 1);
        idle(2);

        // Alternating, three pairs
        run_frame(2'b01, 8'h00, 4'd3, 9, 1'b0, s, bc, da, dc, ec);
        chk("alt_stream", int'(s[8:0]), int'(9'b010101000));
        chk("alt_busy",   bc, 7);
        chk("alt_done_cnt", dc, 1);
        idle(1);

        // Burst of three ones
        run_frame(2'b10, 8'h00, 4'd3, 5, 1'b0, s, bc, da, dc, ec);
        chk("burst_stream", int'(s[4:0]), int'(5'b11100));
        chk("burst_busy",   bc, 4);
        chk("burst_done_at", da, 5);
        idle(1);

        // Pattern 5A, two repetitions
        run_frame(2'b00, 8'h5A, 4'd2, 19, 1'b0, s, bc, da, dc, ec);
        chk("5a_stream", int'(s[18:0]), int'(19'b0101101001011010000));
        chk("5a_busy",   bc, 17);
        idle(1);

        // Rejected starts
        run_frame(2'b11, 8'h00, 4'd5, 3, 1'b0, s, bc, da, dc, ec);
        chk("rsvd_err_cnt", ec, 1);
        chk("rsvd_quiet", int'(s[2:0]) + bc + dc, 0);
        run_frame(2'b00, 8'hFF, 4'd0, 3, 1'b0, s, bc, da, dc, ec);
        chk("len0_err_cnt", ec, 1);
        chk("len0_quiet", int'(s[2:0]) + bc + dc, 0);
        idle(1);

        // Reset mid-frame at data bit 40, then restart immediately after release
        bus.mode = 2'b00; bus.pattern = 8'hFF; bus.length = 4'd15; bus.start = 1'b1;
        dc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            dc += int'(bus.done);
        end
        chk("abort_bit40", int'(bus.outputdata), 1);
        resetn = 1'b0;
        @(negedge clock);
        chk("abort_out",  int'(bus.outputdata), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", dc + int'(bus.done), 0);
        resetn = 1'b1;
        run_frame(2'b10, 8'h00, 4'd1, 3, 1'b0, s, bc, da, dc, ec);
        chk("restart_stream", int'(s[2:0]), int'(3'b100));
        chk("restart_done_at", da, 3);
        idle(1);

        // Start held high: frames repeat with an idle gap
        run_frame(2'b10, 8'h3C, 4'd2, 15, 1'b1, s, bc, da, dc, ec);
        chk("hold_stream",   int'(s[14:0]), int'(15'b110001100011000));
        chk("hold_done_cnt", dc, 3);
        chk("hold_busy",     bc, 9);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
